rom_stream_reader: RTL and testbench



---
 rtl/rom_stream_reader_if.sv | 30 +++
 rtl/rom_stream_reader.sv | 136 +++++++++++++
 tb/tb_rom_stream_reader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if
//   Valid/ready word stream carrying the ROM table out of rom_stream_reader.
//   Ports (signals):
//     out_data  - stream word, driven by the master
//     out_valid - out_data holds a word, driven by the master
//     out_last  - final word of the burst, qualified by out_valid
//     out_ready - consumer accepts the word, driven by the slave
//   A word transfers on a rising clock edge where out_valid && out_ready.
interface rom_stream_reader_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Walks a combinational ROM from a start address for a given number of
//   words and presents the contents as a registered valid/ready burst.
//   The address wraps modulo 2^ADDR_W, so bursts longer than the ROM
//   re-read it cyclically.
//   Ports:
//     clk        - system clock, rising edge
//     rst        - synchronous active-high reset, aborts any burst
//     start      - single-cycle burst request, honoured only in IDLE
//     start_addr - first ROM address of the burst
//     length     - words in the burst (0 = empty burst, straight to DONE)
//     rom_addr   - registered ROM address (the current pointer)
//     rom_data   - combinational ROM output for rom_addr
//     busy       - high while the burst is running
//     done       - one-cycle pulse when the burst completes
//     strm       - output word stream (master side)
module rom_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  rom_stream_reader_if.master strm
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_ZERO = '0;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W:0]   remaining_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;
  logic              last_reg;
  logic              busy_reg;
  logic              done_reg;

  // The output register can take a new word when it is empty or when the
  // word it holds is leaving on this same edge.
  logic capture;
  logic accept;

  assign accept  = valid_reg && strm.out_ready;
  assign capture = (state_reg == RUN) && (remaining_reg != REM_ZERO) &&
                   (!valid_reg || strm.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg  <= 1'b0;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
          if (start) begin
            if (length != REM_ZERO) begin
              ptr_reg       <= start_addr;
              remaining_reg <= length;
              busy_reg      <= 1'b1;
              state_reg     <= RUN;
            end else begin
              // Empty burst: report completion without emitting words.
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        RUN: begin
          if (capture) begin
            data_reg      <= rom_data;
            valid_reg     <= 1'b1;
            last_reg      <= (remaining_reg == REM_ONE);
            ptr_reg       <= ptr_reg + PTR_ONE;
            remaining_reg <= remaining_reg - REM_ONE;
          end else if (accept) begin
            // Only reachable for the final word (remaining is zero), or
            // never otherwise, since any accept with words left captures.
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            if (last_reg) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr       = ptr_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign strm.out_data  = data_reg;
  assign strm.out_valid = valid_reg;
  assign strm.out_last  = last_reg;

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  rom_stream_reader_if #(.DATA_W(DW)) strm ();

  rom_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .strm       (strm)
  );

  // Combinational ROM with random contents.
  logic [DW-1:0] rom_mem [DEPTH];
  assign rom_data = rom_mem[rom_addr];

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   accept_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted word must be the next entry of the expected
  // burst; a stalled word must not change before it is accepted.
  logic [DW-1:0] prev_data;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_last = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", {31'd0, strm.out_valid}, 32'd1);
        check("hold_data", {16'd0, strm.out_data}, {16'd0, prev_data});
        check("hold_last", {31'd0, strm.out_last}, {31'd0, prev_last});
      end
      if (strm.out_valid && strm.out_ready) begin
        check("word_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("data", {16'd0, strm.out_data}, {16'd0, e.d});
          check("last", {31'd0, strm.out_last}, {31'd0, e.l});
          $display("word data=%04h last=%0b expected=%04h/%0b",
                   strm.out_data, strm.out_last, e.d, e.l);
        end
        accept_cnt++;
      end
      if (busy && done)
        check("busy_done_excl", 32'd1, 32'd0);
      prev_valid = strm.out_valid;
      prev_ready = strm.out_ready;
      prev_data  = strm.out_data;
      prev_last  = strm.out_last;
    end
  end

  // Expected burst: ROM[(sa + i) mod DEPTH] for i in 0..len-1, last on the final one.
  task automatic push_expected(input int sa, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.d = rom_mem[(sa + i) % DEPTH];
      e.l = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  // mode 0: ready always high (exact timing checked)
  // mode 1: random ready
  // mode 2: 3 stall cycles on the first word, 2 on the last word
  // inject: extra start pulses while busy and in the DONE cycle
  task automatic do_burst(input int sa, input int len, input int mode, input bit inject);
    int k;
    int stall1;
    int stall2;
    stall1 = 3;
    stall2 = 2;
    strm.out_ready = 1'b1;
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = sa[AW-1:0];
    length     = len[AW:0];
    push_expected(sa, len);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, {31'd0, len > 0});
    k = 0;
    while (!done && k < 200) begin
      if (mode == 0 && k <= len) begin
        check("rom_addr_seq", {28'd0, rom_addr}, (sa + k) % DEPTH);
        check("busy_run", {31'd0, busy}, 32'd1);
      end
      if (mode == 1) begin
        strm.out_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        if (strm.out_valid && stall1 > 0) begin
          strm.out_ready = 1'b0;
          stall1--;
        end else if (strm.out_valid && strm.out_last && stall2 > 0) begin
          strm.out_ready = 1'b0;
          stall2--;
        end else begin
          strm.out_ready = 1'b1;
        end
      end else begin
        strm.out_ready = 1'b1;
      end
      if (inject && k == 2) begin
        start = 1'b1; start_addr = 4'd9; length = 5'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    if (mode == 0)
      check("done_latency", k, (len == 0) ? 0 : len + 1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_valid", {31'd0, strm.out_valid}, 32'd0);
    check("burst_complete", exp_q.size(), 32'd0);
    $display("burst sa=%0d len=%0d mode=%0d done after %0d cycles", sa, len, mode, k);
    strm.out_ready = 1'b1;
    if (inject) begin
      start = 1'b1; start_addr = 4'd9; length = 5'd2;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_pulse_once", {31'd0, done}, 32'd0);
    if (inject) begin
      repeat (3) begin
        @(posedge clk); #1;
        check("ignored_start_busy", {31'd0, busy}, 32'd0);
      end
    end
    exp_q.delete();
  endtask

  initial begin
    int k;
    int sa;
    int len;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'($urandom);
    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    length = '0;
    strm.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
    check("rst_out_data", {16'd0, strm.out_data}, 32'd0);
    check("rst_out_valid", {31'd0, strm.out_valid}, 32'd0);
    check("rst_out_last", {31'd0, strm.out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    do_burst(0, 16, 0, 1'b0);   // full table
    do_burst(14, 4, 0, 1'b0);   // wrap
    do_burst(3, 3, 2, 1'b0);    // backpressure
    do_burst(5, 0, 0, 1'b0);    // zero length
    do_burst(2, 6, 0, 1'b1);    // starts while busy and in DONE
    do_burst(0, 20, 0, 1'b0);   // longer than the ROM

    // Reset after the 5th accepted word of a full-table burst.
    @(posedge clk); #1;
    accept_cnt = 0;
    start = 1'b1; start_addr = 4'd0; length = 5'd16;
    push_expected(0, 16);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (accept_cnt < 5 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_reset_reached", {31'd0, accept_cnt == 5}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", {31'd0, strm.out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_rom_addr", {28'd0, rom_addr}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    do_burst(7, 1, 0, 1'b0);

    // Random bursts under random backpressure.
    for (int n = 0; n < 12; n++) begin
      sa  = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(0, 31);
      do_burst(sa, len, 1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
